// File: rtl/octree_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : octree_frame_ctrl_if
//  Description : Control/handshake bundle between the frame sequencer and the
//                AXI read/write engine, octant_core, bfs_core and output mux.
//  Revision    : 1.0  initial release
// ============================================================================
interface octree_frame_ctrl_if #(
    parameter int ADDR_W      = 32,
    parameter int FRAME_CNT_W = 16
);
    logic                   i_start;
    logic                   i_abort;
    logic                   i_continuous;
    logic [31:0]            i_point_cloud_size;
    logic                   i_read_TxnDone;
    logic                   i_write_TxnDone;
    logic                   i_finish_octree_core;
    logic                   i_need_new_points;
    logic                   i_finish_bfs_core;
    logic                   o_init_read_txn;
    logic [ADDR_W-1:0]      o_read_address;
    logic [31:0]            o_read_len;
    logic                   o_en_octant_core;
    logic                   o_en_bfs_core;
    logic                   o_select_mux;
    logic                   o_finish;
    logic                   o_busy;
    logic [1:0]             o_error;
    logic [2:0]             o_state;
    logic [FRAME_CNT_W-1:0] o_frame_count;

    // Sequencer side
    modport master (
        input  i_start, i_abort, i_continuous, i_point_cloud_size,
               i_read_TxnDone, i_write_TxnDone, i_finish_octree_core,
               i_need_new_points, i_finish_bfs_core,
        output o_init_read_txn, o_read_address, o_read_len, o_en_octant_core,
               o_en_bfs_core, o_select_mux, o_finish, o_busy, o_error,
               o_state, o_frame_count
    );

    // Surrounding system side
    modport slave (
        output i_start, i_abort, i_continuous, i_point_cloud_size,
               i_read_TxnDone, i_write_TxnDone, i_finish_octree_core,
               i_need_new_points, i_finish_bfs_core,
        input  o_init_read_txn, o_read_address, o_read_len, o_en_octant_core,
               o_en_bfs_core, o_select_mux, o_finish, o_busy, o_error,
               o_state, o_frame_count
    );
endinterface
`default_nettype wire

// File: rtl/octree_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : octree_frame_ctrl
//  Description : Frame sequencer: batched DDR point reads, octant_core run,
//                bfs_core write-back, watchdog, error codes, abort,
//                continuous mode and completed-frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
module octree_frame_ctrl #(
    parameter int                ADDR_W           = 32,
    parameter logic [ADDR_W-1:0] DDR_BASE_ADDRESS = 'h0F00_0000,
    parameter int                POINT_BYTES_LOG2 = 3,
    parameter int                BATCH_POINTS     = 256,
    parameter int                TIMEOUT_CYCLES   = 1_000_000,
    parameter int                FRAME_CNT_W      = 16
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    octree_frame_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_READING = 3'd2,
        S_WORK    = 3'd3,
        S_WRITING = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [31:0] c_BATCH      = 32'(BATCH_POINTS);
    localparam logic [31:0] c_WDOG_LIMIT = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  c_ERR_NONE   = 2'd0;
    localparam logic [1:0]  c_ERR_TIMEOUT= 2'd1;
    localparam logic [1:0]  c_ERR_STARVE = 2'd2;
    localparam logic [1:0]  c_ERR_EMPTY  = 2'd3;

    state_t                 r_state,    w_state_next;
    logic [31:0]            r_size,     w_size_next;
    logic [31:0]            r_consumed, w_consumed_next;
    logic [31:0]            r_read_len, w_read_len_next;
    logic [ADDR_W-1:0]      r_read_addr, w_read_addr_next;
    logic                   r_init,     w_init_next;
    logic                   r_en_oct,   w_en_oct_next;
    logic                   r_en_bfs,   w_en_bfs_next;
    logic                   r_mux,      w_mux_next;
    logic                   r_finish,   w_finish_next;
    logic                   r_busy,     w_busy_next;
    logic [1:0]             r_error,    w_error_next;
    logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
    logic                   r_wr_seen,  w_wr_seen_next;
    logic                   r_bfs_seen, w_bfs_seen_next;
    logic [31:0]            r_wdog,     w_wdog_next;

    logic        w_timed;
    logic        w_wr_acc;
    logic        w_bfs_acc;
    logic [31:0] w_remaining;

    // Next-state and next-output computation for every registered signal
    always_comb begin
        w_state_next     = r_state;
        w_size_next      = r_size;
        w_consumed_next  = r_consumed;
        w_read_len_next  = r_read_len;
        w_read_addr_next = r_read_addr;
        w_init_next      = 1'b0;
        w_en_oct_next    = r_en_oct;
        w_en_bfs_next    = r_en_bfs;
        w_mux_next       = r_mux;
        w_finish_next    = 1'b0;
        w_error_next     = r_error;
        w_frame_cnt_next = r_frame_cnt;
        w_timed          = (r_state == S_READING) || (r_state == S_WORK) || (r_state == S_WRITING);
        w_wr_acc         = r_wr_seen  | bus.i_write_TxnDone;
        w_bfs_acc        = r_bfs_seen | bus.i_finish_bfs_core;
        w_remaining      = r_size - r_consumed;

        case (r_state)
            S_IDLE: begin
                w_en_oct_next = 1'b0;
                w_en_bfs_next = 1'b0;
                w_mux_next    = 1'b0;
                if (bus.i_start) begin
                    w_size_next     = bus.i_point_cloud_size;
                    w_consumed_next = 32'd0;
                    if (bus.i_point_cloud_size == 32'd0) begin
                        w_state_next = S_ERROR;
                        w_error_next = c_ERR_EMPTY;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            // A read-done pulse here belongs to no request of ours and is dropped
            S_REQ: w_state_next = S_READING;
            S_READING: begin
                if (bus.i_read_TxnDone) begin
                    w_consumed_next = r_consumed + r_read_len;
                    w_en_oct_next   = 1'b1;
                    w_state_next    = S_WORK;
                end
            end
            S_WORK: begin
                if (bus.i_finish_octree_core) begin
                    w_state_next  = S_WRITING;
                    w_en_oct_next = 1'b0;
                    w_en_bfs_next = 1'b1;
                    w_mux_next    = 1'b1;
                end else if (bus.i_need_new_points) begin
                    if (w_remaining != 32'd0) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_ERROR;
                        w_error_next = c_ERR_STARVE;
                    end
                end
            end
            S_WRITING: begin
                if (w_wr_acc && w_bfs_acc) begin
                    w_state_next     = S_DONE;
                    w_en_bfs_next    = 1'b0;
                    w_mux_next       = 1'b0;
                    w_finish_next    = 1'b1;
                    w_frame_cnt_next = r_frame_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_size_next     = bus.i_point_cloud_size;
                w_consumed_next = 32'd0;
                if (bus.i_continuous && (bus.i_point_cloud_size != 32'd0)) begin
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ERROR: begin
                if (bus.i_start) begin
                    w_state_next = S_IDLE;
                    w_error_next = c_ERR_NONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Watchdog fires only when the state made no progress this cycle
        if (w_timed && (TIMEOUT_CYCLES != 0) && (r_wdog == c_WDOG_LIMIT) && (w_state_next == r_state)) begin
            w_state_next = S_ERROR;
            w_error_next = c_ERR_TIMEOUT;
        end

        // Abort discards whatever the state logic decided this cycle
        if (bus.i_abort) begin
            w_state_next     = S_IDLE;
            w_error_next     = r_error;
            w_frame_cnt_next = r_frame_cnt;
            w_finish_next    = 1'b0;
        end

        if ((w_state_next == S_ERROR) || (w_state_next == S_IDLE)) begin
            w_en_oct_next = 1'b0;
            w_en_bfs_next = 1'b0;
            w_mux_next    = 1'b0;
        end

        // Batch parameters are loaded on entry to REQ so they are valid with the launch pulse
        if (w_state_next == S_REQ) begin
            w_init_next      = 1'b1;
            w_read_len_next  = ((w_size_next - w_consumed_next) > c_BATCH) ?
                               c_BATCH : (w_size_next - w_consumed_next);
            w_read_addr_next = DDR_BASE_ADDRESS +
                               ADDR_W'({32'd0, w_consumed_next} << POINT_BYTES_LOG2);
        end

        w_busy_next     = !((w_state_next == S_IDLE) || (w_state_next == S_ERROR));
        w_wr_seen_next  = (r_state == S_WRITING) && (w_state_next == S_WRITING) && w_wr_acc;
        w_bfs_seen_next = (r_state == S_WRITING) && (w_state_next == S_WRITING) && w_bfs_acc;
        w_wdog_next     = (!w_timed || (w_state_next != r_state)) ? 32'd0 : r_wdog + 32'd1;
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_size      <= 32'd0;
            r_consumed  <= 32'd0;
            r_read_len  <= 32'd0;
            r_read_addr <= DDR_BASE_ADDRESS;
            r_init      <= 1'b0;
            r_en_oct    <= 1'b0;
            r_en_bfs    <= 1'b0;
            r_mux       <= 1'b0;
            r_finish    <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= c_ERR_NONE;
            r_frame_cnt <= '0;
            r_wr_seen   <= 1'b0;
            r_bfs_seen  <= 1'b0;
            r_wdog      <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_size      <= w_size_next;
            r_consumed  <= w_consumed_next;
            r_read_len  <= w_read_len_next;
            r_read_addr <= w_read_addr_next;
            r_init      <= w_init_next;
            r_en_oct    <= w_en_oct_next;
            r_en_bfs    <= w_en_bfs_next;
            r_mux       <= w_mux_next;
            r_finish    <= w_finish_next;
            r_busy      <= w_busy_next;
            r_error     <= w_error_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_wr_seen   <= w_wr_seen_next;
            r_bfs_seen  <= w_bfs_seen_next;
            r_wdog      <= w_wdog_next;
        end
    end

    assign bus.o_init_read_txn  = r_init;
    assign bus.o_read_address   = r_read_addr;
    assign bus.o_read_len       = r_read_len;
    assign bus.o_en_octant_core = r_en_oct;
    assign bus.o_en_bfs_core    = r_en_bfs;
    assign bus.o_select_mux     = r_mux;
    assign bus.o_finish         = r_finish;
    assign bus.o_busy           = r_busy;
    assign bus.o_error          = r_error;
    assign bus.o_state          = r_state;
    assign bus.o_frame_count    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_octree_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_octree_frame_ctrl
//  Description : Directed table-driven bench for octree_frame_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_octree_frame_ctrl;

    localparam logic [31:0] B = 32'h0F00_0000;

    // State encodings
    localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_RD = 3'd2, ST_WORK = 3'd3,
                           ST_WR = 3'd4, ST_DONE = 3'd5, ST_ERR = 3'd6;
    // Flag vectors {init, en_oct, en_bfs, mux, finish, busy}
    localparam logic [5:0] F_NONE = 6'b000000, F_BUSY = 6'b000001, F_REQ0 = 6'b100001,
                           F_REQ1 = 6'b110001, F_OCT = 6'b010001, F_WR = 6'b001101,
                           F_DONE = 6'b000011;
    // Stimulus bits {start, abort, cont, rd_done, wr_done, fin_oct, need, fin_bfs}
    localparam logic [7:0] I_NONE = 8'h00, I_START = 8'h80, I_ABORT = 8'h40, I_CONT = 8'h20,
                           I_RD = 8'h10, I_WRD = 8'h08, I_FOCT = 8'h04, I_NEED = 8'h02,
                           I_FBFS = 8'h01;

    typedef struct {
        logic [7:0]  stim;
        logic [31:0] size;
        logic [2:0]  st;
        logic [5:0]  fl;
        logic [1:0]  err;
        logic [15:0] fc;
        logic [31:0] addr;
        logic [31:0] len;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl[$];

    octree_frame_ctrl_if #(.ADDR_W(32), .FRAME_CNT_W(16)) bus ();

    octree_frame_ctrl #(
        .ADDR_W(32), .DDR_BASE_ADDRESS(B), .POINT_BYTES_LOG2(3),
        .BATCH_POINTS(256), .TIMEOUT_CYCLES(100), .FRAME_CNT_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic [7:0] s, input logic [31:0] sz, input logic [2:0] st,
                                input logic [5:0] fl, input logic [1:0] e, input logic [15:0] fc,
                                input logic [31:0] a, input logic [31:0] l);
        vec_t v;
        v.stim = s; v.size = sz; v.st = st; v.fl = fl; v.err = e; v.fc = fc; v.addr = a; v.len = l;
        tbl.push_back(v);
    endfunction

    task automatic step(input logic [7:0] s, input logic [31:0] sz);
        bus.i_start              = s[7];
        bus.i_abort              = s[6];
        bus.i_continuous         = s[5];
        bus.i_read_TxnDone       = s[4];
        bus.i_write_TxnDone      = s[3];
        bus.i_finish_octree_core = s[2];
        bus.i_need_new_points    = s[1];
        bus.i_finish_bfs_core    = s[0];
        bus.i_point_cloud_size   = sz;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string name, input logic [2:0] st, input logic [5:0] fl,
                              input logic [1:0] e, input logic [15:0] fc,
                              input logic [31:0] a, input logic [31:0] l);
        logic [5:0] afl;
        afl = {bus.o_init_read_txn, bus.o_en_octant_core, bus.o_en_bfs_core,
               bus.o_select_mux, bus.o_finish, bus.o_busy};
        n_total++;
        if (bus.o_state === st && afl === fl && bus.o_error === e && bus.o_frame_count === fc &&
            bus.o_read_address === a && bus.o_read_len === l) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d fl=%b err=%0d fc=%0d addr=%h len=%0d, want st=%0d fl=%b err=%0d fc=%0d addr=%h len=%0d",
                     name, bus.o_state, afl, bus.o_error, bus.o_frame_count, bus.o_read_address,
                     bus.o_read_len, st, fl, e, fc, a, l);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    initial begin
        // Frame of 600 points: three batches, finish+need together, write and bfs together
        add(I_START,       32'd600, ST_REQ,  F_REQ0, 2'd0, 16'd0, B,              32'd256);
        add(I_NONE,        32'd600, ST_RD,   F_BUSY, 2'd0, 16'd0, B,              32'd256);
        add(I_RD,          32'd600, ST_WORK, F_OCT,  2'd0, 16'd0, B,              32'd256);
        add(I_NEED,        32'd600, ST_REQ,  F_REQ1, 2'd0, 16'd0, 32'h0F00_0800,  32'd256);
        add(I_RD,          32'd600, ST_RD,   F_OCT,  2'd0, 16'd0, 32'h0F00_0800,  32'd256);
        add(I_RD,          32'd600, ST_WORK, F_OCT,  2'd0, 16'd0, 32'h0F00_0800,  32'd256);
        add(I_NEED,        32'd600, ST_REQ,  F_REQ1, 2'd0, 16'd0, 32'h0F00_1000,  32'd88);
        add(I_NONE,        32'd600, ST_RD,   F_OCT,  2'd0, 16'd0, 32'h0F00_1000,  32'd88);
        add(I_RD,          32'd600, ST_WORK, F_OCT,  2'd0, 16'd0, 32'h0F00_1000,  32'd88);
        add(I_FOCT|I_NEED, 32'd600, ST_WR,   F_WR,   2'd0, 16'd0, 32'h0F00_1000,  32'd88);
        add(I_WRD|I_FBFS,  32'd600, ST_DONE, F_DONE, 2'd0, 16'd1, 32'h0F00_1000,  32'd88);
        add(I_NONE,        32'd600, ST_IDLE, F_NONE, 2'd0, 16'd1, 32'h0F00_1000,  32'd88);
        // Frame of 10: write done at t, bfs finish at t+5
        add(I_START,       32'd10,  ST_REQ,  F_REQ0, 2'd0, 16'd1, B, 32'd10);
        add(I_NONE,        32'd10,  ST_RD,   F_BUSY, 2'd0, 16'd1, B, 32'd10);
        add(I_RD,          32'd10,  ST_WORK, F_OCT,  2'd0, 16'd1, B, 32'd10);
        add(I_FOCT,        32'd10,  ST_WR,   F_WR,   2'd0, 16'd1, B, 32'd10);
        add(I_WRD,         32'd10,  ST_WR,   F_WR,   2'd0, 16'd1, B, 32'd10);
        for (int i = 0; i < 4; i++)
            add(I_NONE,    32'd10,  ST_WR,   F_WR,   2'd0, 16'd1, B, 32'd10);
        add(I_FBFS,        32'd10,  ST_DONE, F_DONE, 2'd0, 16'd2, B, 32'd10);
        add(I_NONE,        32'd10,  ST_IDLE, F_NONE, 2'd0, 16'd2, B, 32'd10);
        // Starvation with 256 points, then clear
        add(I_START,       32'd256, ST_REQ,  F_REQ0, 2'd0, 16'd2, B, 32'd256);
        add(I_NONE,        32'd256, ST_RD,   F_BUSY, 2'd0, 16'd2, B, 32'd256);
        add(I_RD,          32'd256, ST_WORK, F_OCT,  2'd0, 16'd2, B, 32'd256);
        add(I_NEED,        32'd256, ST_ERR,  F_NONE, 2'd2, 16'd2, B, 32'd256);
        add(I_NONE,        32'd256, ST_ERR,  F_NONE, 2'd2, 16'd2, B, 32'd256);
        add(I_START,       32'd256, ST_IDLE, F_NONE, 2'd0, 16'd2, B, 32'd256);
        // Empty frame, then clear
        add(I_START,       32'd0,   ST_ERR,  F_NONE, 2'd3, 16'd2, B, 32'd256);
        add(I_START,       32'd0,   ST_IDLE, F_NONE, 2'd0, 16'd2, B, 32'd256);
        // Abort in WORK
        add(I_START,       32'd10,  ST_REQ,  F_REQ0, 2'd0, 16'd2, B, 32'd10);
        add(I_NONE,        32'd10,  ST_RD,   F_BUSY, 2'd0, 16'd2, B, 32'd10);
        add(I_RD,          32'd10,  ST_WORK, F_OCT,  2'd0, 16'd2, B, 32'd10);
        add(I_ABORT|I_NEED,32'd10,  ST_IDLE, F_NONE, 2'd0, 16'd2, B, 32'd10);

        step(I_NONE, 32'd0);
        step(I_NONE, 32'd0);
        rst = 1'b0;
        expect_all("reset", ST_IDLE, F_NONE, 2'd0, 16'd0, B, 32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].stim, tbl[i].size);
            expect_all($sformatf("row%0d", i), tbl[i].st, tbl[i].fl, tbl[i].err, tbl[i].fc,
                       tbl[i].addr, tbl[i].len);
        end

        // Timeout: 100 cycles in READING without read completion
        step(I_START, 32'd10);
        check("to_req", 32'(bus.o_state), 32'(ST_REQ));
        step(I_NONE, 32'd10);
        check("to_reading", 32'(bus.o_state), 32'(ST_RD));
        repeat (99) step(I_NONE, 32'd10);
        check("to_still_reading", 32'(bus.o_state), 32'(ST_RD));
        step(I_NONE, 32'd10);
        expect_all("to_error", ST_ERR, F_NONE, 2'd1, 16'd2, B, 32'd10);
        step(I_START, 32'd10);
        expect_all("to_clear", ST_IDLE, F_NONE, 2'd0, 16'd2, B, 32'd10);

        // Reset in the middle of a frame
        step(I_START, 32'd600);
        step(I_NONE, 32'd600);
        step(I_RD, 32'd600);
        rst = 1'b1;
        step(I_NEED, 32'd600);
        expect_all("mid_reset", ST_IDLE, F_NONE, 2'd0, 16'd0, B, 32'd0);
        rst = 1'b0;

        // Continuous mode: three back-to-back frames of 10 points
        step(I_START|I_CONT, 32'd10);
        expect_all("cont_req0", ST_REQ, F_REQ0, 2'd0, 16'd0, B, 32'd10);
        for (int f = 0; f < 3; f++) begin
            step(I_CONT, 32'd10);
            check($sformatf("cont_rd%0d", f), 32'(bus.o_state), 32'(ST_RD));
            step(I_CONT|I_RD, 32'd10);
            check($sformatf("cont_work%0d", f), 32'(bus.o_state), 32'(ST_WORK));
            step(I_CONT|I_FOCT, 32'd10);
            check($sformatf("cont_wr%0d", f), 32'(bus.o_state), 32'(ST_WR));
            step(I_CONT|I_WRD|I_FBFS, 32'd10);
            expect_all($sformatf("cont_done%0d", f), ST_DONE, F_DONE, 2'd0, 16'(f + 1), B, 32'd10);
            if (f < 2) begin
                step(I_CONT, 32'd10);
                expect_all($sformatf("cont_req%0d", f + 1), ST_REQ, F_REQ0, 2'd0, 16'(f + 1), B, 32'd10);
            end else begin
                step(I_NONE, 32'd10);
                expect_all("cont_idle", ST_IDLE, F_NONE, 2'd0, 16'd3, B, 32'd10);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
